// File: rtl/pwm_decoder_multi_if.sv
// ---------------------------------------------------------------------------
// pwm_decoder_multi_if
//   Bundles the per-channel PWM inputs, enables and coded results that pass
//   between the receiver side and the register bank.
//
//   i_pwm         [NUM_CH]     raw asynchronous PWM inputs, bit n = channel n
//   i_ch_enable   [NUM_CH]     per-channel enable (level)
//   o_pwm_ready   [NUM_CH]     one-cycle result strobe per channel
//   o_pwm_value   [16*NUM_CH]  channel n result in bits [16n+15:16n]
//   o_signal_loss [NUM_CH]     sticky per-channel loss flag
//
//   master : the side that drives the inputs and consumes the results
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface pwm_decoder_multi_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0]    i_pwm;
    logic [NUM_CH-1:0]    i_ch_enable;
    logic [NUM_CH-1:0]    o_pwm_ready;
    logic [16*NUM_CH-1:0] o_pwm_value;
    logic [NUM_CH-1:0]    o_signal_loss;

    modport master (
        output i_pwm,
        output i_ch_enable,
        input  o_pwm_ready,
        input  o_pwm_value,
        input  o_signal_loss
    );

    modport slave (
        input  i_pwm,
        input  i_ch_enable,
        output o_pwm_ready,
        output o_pwm_value,
        output o_signal_loss
    );
endinterface

// File: rtl/pwm_decoder_multi.sv
// ---------------------------------------------------------------------------
// pwm_decoder_multi
//   Multi-channel RC PWM decoder. Every channel measures its high time and
//   watches for a low-time timeout in 1 us units, using one shared,
//   free-running 1 MHz tick. Each finished measurement is reported as a
//   coded 16-bit word:
//     value[15:14] code : 00 OK, 01 SHORT, 10 HIGH_TIMEOUT, 11 LOW_TIMEOUT
//     value[13:0]  count in us
//
//   i_clk     system clock (CLK_FREQ Hz, integer multiple of 1 MHz, >= 2 MHz)
//   i_resetn  asynchronous active-low reset
//   bus       pwm_decoder_multi_if slave port (inputs, enables, results)
// ---------------------------------------------------------------------------
module pwm_decoder_multi #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int NUM_CH     = 4,
    parameter int ON_MIN_US  = 800,
    parameter int ON_MAX_US  = 2600,
    parameter int OFF_MAX_US = 20000
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    pwm_decoder_multi_if.slave   bus
);

    localparam int DIV = CLK_FREQ / 1_000_000;
    localparam int PW  = $clog2(DIV);

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [15:0]   ON_MIN     = 16'(ON_MIN_US);
    localparam logic [15:0]   ON_MAX     = 16'(ON_MAX_US);
    localparam logic [15:0]   OFF_MAX    = 16'(OFF_MAX_US);

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_SHORT   = 2'b01;
    localparam logic [1:0] CODE_HIGH_TO = 2'b10;
    localparam logic [1:0] CODE_LOW_TO  = 2'b11;

    localparam logic [15:0] VALUE_RESET = 16'hC000;

    typedef enum logic [1:0] {
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // Shared 1 us tick. Never restarted by channel activity, so every
    // measurement quantises to +/-1 us.
    // -----------------------------------------------------------------------
    logic [PW-1:0] presc_q;
    logic          tick;

    assign tick = (presc_q == PRESC_LAST);

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // 2-FF synchronisers; sync2_q is the channel state seen by the FSMs.
    // -----------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1_q;
    logic [NUM_CH-1:0] sync2_q;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.i_pwm;
            sync2_q <= sync1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel measurement FSMs
    // -----------------------------------------------------------------------
    state_t            state_q   [NUM_CH];
    logic [15:0]       on_cnt_q  [NUM_CH];
    logic [15:0]       off_cnt_q [NUM_CH];
    logic [15:0]       value_q   [NUM_CH];
    logic [NUM_CH-1:0] ready_q;
    logic [NUM_CH-1:0] loss_q;

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            // NOTE: these per-channel arrays are plain flip-flops rather than
            // a RAM, so they take the asynchronous reset like any register.
            for (int n = 0; n < NUM_CH; n++) begin
                state_q[n]   <= ST_LOW;
                on_cnt_q[n]  <= '0;
                off_cnt_q[n] <= '0;
                value_q[n]   <= VALUE_RESET;
            end
            ready_q <= '0;
            loss_q  <= '1;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                // Strobe defaults low; only an emit raises it for the one
                // cycle the FSM spends in DONE.
                ready_q[n] <= 1'b0;

                if (!bus.i_ch_enable[n]) begin
                    // Disabled: abort any measurement, keep value and loss.
                    state_q[n]   <= ST_LOW;
                    on_cnt_q[n]  <= '0;
                    off_cnt_q[n] <= '0;
                end else begin
                    unique case (state_q[n])
                        ST_LOW: begin
                            if (sync2_q[n]) begin
                                on_cnt_q[n] <= '0;
                                state_q[n]  <= ST_HIGH;
                            end else if (tick) begin
                                if (off_cnt_q[n] < OFF_MAX) begin
                                    off_cnt_q[n] <= off_cnt_q[n] + 16'd1;
                                end else begin
                                    // off_cnt is wider than the 14-bit field,
                                    // so the reported count saturates.
                                    value_q[n] <= {CODE_LOW_TO, 14'h3FFF};
                                    loss_q[n]  <= 1'b1;
                                    ready_q[n] <= 1'b1;
                                    state_q[n] <= ST_DONE;
                                end
                            end
                        end

                        ST_HIGH: begin
                            if (!sync2_q[n]) begin
                                if (on_cnt_q[n] < ON_MIN) begin
                                    // A runt pulse is reported but does not
                                    // prove the link is healthy.
                                    value_q[n] <= {CODE_SHORT, on_cnt_q[n][13:0]};
                                end else begin
                                    value_q[n] <= {CODE_OK, on_cnt_q[n][13:0]};
                                    loss_q[n]  <= 1'b0;
                                end
                                ready_q[n] <= 1'b1;
                                state_q[n] <= ST_DONE;
                            end else if (tick) begin
                                if (on_cnt_q[n] < ON_MAX) begin
                                    on_cnt_q[n] <= on_cnt_q[n] + 16'd1;
                                end else begin
                                    value_q[n] <= {CODE_HIGH_TO, on_cnt_q[n][13:0]};
                                    loss_q[n]  <= 1'b1;
                                    ready_q[n] <= 1'b1;
                                    state_q[n] <= ST_DONE;
                                end
                            end
                        end

                        ST_DONE: begin
                            // Single-cycle report state; a still-high input
                            // starts a fresh measurement from LOW next cycle.
                            on_cnt_q[n]  <= '0;
                            off_cnt_q[n] <= '0;
                            state_q[n]   <= ST_LOW;
                        end

                        default: begin
                            state_q[n] <= ST_LOW;
                        end
                    endcase
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output packing
    // -----------------------------------------------------------------------
    // NOTE: the combinational block assigns a default before the loop so no
    // bit is left unassigned on any path, which would infer a latch.
    always_comb begin
        bus.o_pwm_value = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            bus.o_pwm_value[16*n +: 16] = value_q[n];
        end
    end

    assign bus.o_pwm_ready   = ready_q;
    assign bus.o_signal_loss = loss_q;

endmodule

// File: tb/tb_pwm_decoder_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_decoder_multi
//   Self-checking bench for pwm_decoder_multi. Uses a 4 MHz clock (4 cycles
//   per us) and scaled-down limits so every timeout fits in a short run:
//   ON_MIN_US = 20, ON_MAX_US = 60, OFF_MAX_US = 300.
// ---------------------------------------------------------------------------
module tb_pwm_decoder_multi;

    localparam int CLK_FREQ   = 4_000_000;
    localparam int NUM_CH     = 4;
    localparam int ON_MIN_US  = 20;
    localparam int ON_MAX_US  = 60;
    localparam int OFF_MAX_US = 300;
    localparam int DIV        = CLK_FREQ / 1_000_000;

    logic i_clk;
    logic i_resetn;

    pwm_decoder_multi_if #(.NUM_CH(NUM_CH)) bus ();

    pwm_decoder_multi #(
        .CLK_FREQ  (CLK_FREQ),
        .NUM_CH    (NUM_CH),
        .ON_MIN_US (ON_MIN_US),
        .ON_MAX_US (ON_MAX_US),
        .OFF_MAX_US(OFF_MAX_US)
    ) dut (
        .i_clk   (i_clk),
        .i_resetn(i_resetn),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int                n_cmp = 0;
    int                n_bad = 0;
    logic [NUM_CH-1:0] seen;

    typedef struct {
        int         ch;
        int         high_us;
        logic [1:0] code;
        int         count;
        bit         loss;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [15:0] lane(input int ch);
        return bus.o_pwm_value[16*ch +: 16];
    endfunction

    // Advance n cycles, sampling on the falling edge and accumulating strobes.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge i_clk);
            seen |= bus.o_pwm_ready;
        end
    endtask

    // Bounded wait for a strobe on one channel; cyc counts falling edges.
    task automatic wait_ready(input int ch, input int max_cyc, output int cyc, output bit found);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < max_cyc) begin
            @(negedge i_clk);
            cyc++;
            seen |= bus.o_pwm_ready;
            if (bus.o_pwm_ready[ch]) found = 1'b1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ready"}, 32'(bus.o_pwm_ready), 32'h0);
        check({tag, " loss"}, 32'(bus.o_signal_loss), 32'hF);
        for (int c = 0; c < NUM_CH; c++)
            check($sformatf("%s lane%0d", tag, c), 32'(lane(c)), 32'hC000);
    endtask

    // Pulse one channel high, then wait for and check its report.
    task automatic pulse_and_check(input string tag, input int ch, input int us,
                                   input logic [1:0] code, input int count, input bit loss);
        int cyc;
        bit found;
        bus.i_pwm[ch] = 1'b1;
        step(us * DIV);
        bus.i_pwm[ch] = 1'b0;
        wait_ready(ch, 16, cyc, found);
        check({tag, " ready seen"}, 32'(found), 32'h1);
        check({tag, " code"}, 32'(lane(ch)[15:14]), 32'(code));
        check_range({tag, " count"}, int'(lane(ch)[13:0]), count - 1, count + 1);
        check({tag, " loss"}, 32'(bus.o_signal_loss[ch]), 32'(loss));
        step(1);
        check({tag, " ready one cycle"}, 32'(bus.o_pwm_ready[ch]), 32'h0);
        step(5 * DIV);
    endtask

    initial begin
        int          cyc;
        bit          found;
        logic [15:0] held_value;
        logic        held_loss;

        // {ch, high_us, code, count_us, loss_after}
        vecs[0] = '{2, 15, 2'b01, 15, 1'b1};  // SHORT right after reset keeps loss
        vecs[1] = '{2, 40, 2'b00, 40, 1'b0};  // valid pulse clears loss
        vecs[2] = '{0, 30, 2'b00, 30, 1'b0};
        vecs[3] = '{0, 59, 2'b00, 59, 1'b0};  // just below HIGH timeout
        vecs[4] = '{3, 25, 2'b00, 25, 1'b0};
        vecs[5] = '{3, 10, 2'b01, 10, 1'b0};  // SHORT leaves loss clear
        vecs[6] = '{3, 19, 2'b01, 19, 1'b0};  // just below ON_MIN
        vecs[7] = '{1, 21, 2'b00, 21, 1'b0};  // just above ON_MIN
        vecs[8] = '{1,  1, 2'b01,  1, 1'b0};

        seen            = '0;
        i_resetn        = 1'b0;
        bus.i_pwm       = '0;
        bus.i_ch_enable = '1;

        // Reset state, during and just after reset.
        step(3);
        check_reset_state("reset");
        i_resetn = 1'b1;
        step(4);
        check_reset_state("post-reset");

        // Table-driven pulse vectors.
        for (int i = 0; i < 9; i++)
            pulse_and_check($sformatf("v%0d", i), vecs[i].ch, vecs[i].high_us,
                            vecs[i].code, vecs[i].count, vecs[i].loss);

        // Stuck-high ch1: HIGH_TIMEOUT at ON_MAX, then again one period later.
        bus.i_pwm[1] = 1'b1;
        wait_ready(1, (ON_MAX_US + 5) * DIV, cyc, found);
        check("hto1 ready seen", 32'(found), 32'h1);
        check_range("hto1 latency", cyc, ON_MAX_US * DIV, (ON_MAX_US + 2) * DIV);
        check("hto1 value", 32'(lane(1)), 32'h803C);
        check("hto1 loss", 32'(bus.o_signal_loss[1]), 32'h1);
        wait_ready(1, (ON_MAX_US + 5) * DIV, cyc, found);
        check("hto2 ready seen", 32'(found), 32'h1);
        check_range("hto2 interval", cyc, ON_MAX_US * DIV, (ON_MAX_US + 2) * DIV);
        check("hto2 value", 32'(lane(1)), 32'h803C);
        bus.i_pwm[1] = 1'b0;
        step(20);

        // Stuck-low ch2: LOW_TIMEOUT, then a repeat one period later.
        wait_ready(2, (OFF_MAX_US + 5) * DIV, cyc, found);
        check("lto1 ready seen", 32'(found), 32'h1);
        check("lto1 value", 32'(lane(2)), 32'hFFFF);
        check("lto1 loss", 32'(bus.o_signal_loss[2]), 32'h1);
        wait_ready(2, (OFF_MAX_US + 5) * DIV, cyc, found);
        check("lto2 ready seen", 32'(found), 32'h1);
        check_range("lto2 interval", cyc, OFF_MAX_US * DIV, (OFF_MAX_US + 2) * DIV);
        check("lto2 value", 32'(lane(2)), 32'hFFFF);

        // Same-cycle pulses on ch0/ch3 with ch1 disabled. A brief disable of
        // ch0/ch3 first restarts both in LOW so their timing is aligned.
        bus.i_ch_enable = 4'b0100;
        step(2);
        bus.i_ch_enable = 4'b1101;
        step(2);
        held_value = lane(1);
        held_loss  = bus.o_signal_loss[1];
        seen       = '0;
        bus.i_pwm  = 4'b1011;
        step(30 * DIV);
        bus.i_pwm[0] = 1'b0;
        bus.i_pwm[3] = 1'b0;
        wait_ready(0, 16, cyc, found);
        check("sim ch0 ready seen", 32'(found), 32'h1);
        check("sim ch3 same cycle", 32'(bus.o_pwm_ready[3]), 32'h1);
        check_range("sim ch0 count", int'(lane(0)), 29, 31);
        check_range("sim ch3 count", int'(lane(3)), 29, 31);
        step(5 * DIV);
        bus.i_pwm[1] = 1'b0;
        step(10 * DIV);
        check("dis ch1 no ready", 32'(seen[1]), 32'h0);
        check("dis ch1 lane held", 32'(lane(1)), 32'(held_value));
        check("dis ch1 loss held", 32'(bus.o_signal_loss[1]), 32'(held_loss));

        // Abort mid-measurement by disabling, then resume after re-enable.
        bus.i_ch_enable[1] = 1'b1;
        step(5 * DIV);
        bus.i_pwm[1] = 1'b1;
        step(20 * DIV);
        bus.i_ch_enable[1] = 1'b0;
        step(5);
        bus.i_pwm[1] = 1'b0;
        seen = '0;
        step(10 * DIV);
        check("abort ch1 no ready", 32'(seen[1]), 32'h0);
        bus.i_ch_enable[1] = 1'b1;
        step(5 * DIV);
        pulse_and_check("resume ch1", 1, 30, 2'b00, 30, 1'b0);

        // Reset mid-pulse on ch0, released while the input is still high.
        bus.i_pwm[0] = 1'b1;
        step(30 * DIV);
        i_resetn = 1'b0;
        step(4);
        check_reset_state("mid-reset");
        i_resetn = 1'b1;
        step(40);
        bus.i_pwm[0] = 1'b0;
        wait_ready(0, 16, cyc, found);
        check("partial ready seen", 32'(found), 32'h1);
        check("partial code", 32'(lane(0)[15:14]), 32'h1);
        check_range("partial count", int'(lane(0)[13:0]), 9, 11);
        check("partial loss", 32'(bus.o_signal_loss[0]), 32'h1);
        step(5 * DIV);
        pulse_and_check("after reset", 0, 40, 2'b00, 40, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
